// File: rtl/vend_pkg.sv
// Definitions shared by the coin link transmitter and the vending machine core.
package vend_pkg;

    typedef enum logic [1:0] {
        NICKEL  = 2'b00,
        DIME    = 2'b01,
        QUARTER = 2'b10,
        DOLLAR  = 2'b11
    } coin_code_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_GAP
    } tx_state_t;

    localparam logic FRAME_START = 1'b0;
    localparam logic FRAME_STOP  = 1'b1;

    localparam int unsigned NICKEL_CENTS  = 5;
    localparam int unsigned DIME_CENTS    = 10;
    localparam int unsigned QUARTER_CENTS = 25;
    localparam int unsigned DOLLAR_CENTS  = 100;

endpackage

// File: rtl/coin_fifo.sv
// Synchronous pending-coin queue; pushes when full and pops when empty are ignored.
module coin_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/coin_serial_tx.sv
// Serial coin link transmitter: queues sensor coin events and sends each as
// start / LSB-first data / even parity / stop, followed by an idle gap.
module coin_serial_tx #(
    parameter int unsigned COIN_BITS  = 2,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coin_valid,
    input  logic [COIN_BITS-1:0] coin_code,
    output logic                 coin_ready,
    output logic                 serialOut,
    output logic                 busy,
    output logic                 tx_done
);

    import vend_pkg::*;

    localparam int unsigned CW = $clog2(BIT_CYCLES) + 1;
    localparam int unsigned BW = $clog2(COIN_BITS) + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;

    tx_state_t              state, state_n;
    logic [CW-1:0]          cyc, cyc_n;
    logic [BW-1:0]          bit_cnt, bit_n;
    logic [GW-1:0]          gap_cnt, gap_n;
    logic [COIN_BITS-1:0]   shift, shift_n, shifted;
    logic                   parity, par_n;
    logic                   line, line_n;
    logic                   last_cycle;
    logic                   pop;
    logic                   full, empty;
    logic [COIN_BITS-1:0]   head;
    logic [$clog2(FIFO_DEPTH):0] count;

    coin_fifo #(
        .WIDTH(COIN_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (coin_valid && coin_ready),
        .push_data (coin_code),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign coin_ready = !reset && !full;
    assign serialOut  = line;
    assign busy       = (state != TX_IDLE) || (count != '0);
    assign last_cycle = (cyc == CW'(BIT_CYCLES - 1));
    assign tx_done    = (state == TX_STOP) && last_cycle;
    assign shifted    = shift >> 1;

    // state always names the bit currently on the line; line_n is loaded on the
    // same edge the state changes so serialOut stays a plain register.
    always_comb begin
        state_n = state;
        cyc_n   = last_cycle ? '0 : cyc + CW'(1);
        bit_n   = bit_cnt;
        gap_n   = gap_cnt;
        shift_n = shift;
        par_n   = parity;
        line_n  = line;
        pop     = 1'b0;
        case (state)
            TX_IDLE: begin
                cyc_n  = '0;
                line_n = FRAME_STOP;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    par_n   = ^head;
                    bit_n   = '0;
                    line_n  = FRAME_START;
                    state_n = TX_START;
                end
            end
            TX_START: begin
                if (last_cycle) begin
                    line_n  = shift[0];
                    state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (last_cycle) begin
                    if (bit_cnt == BW'(COIN_BITS - 1)) begin
                        line_n  = parity;
                        state_n = TX_PARITY;
                    end else begin
                        shift_n = shifted;
                        line_n  = shifted[0];
                        bit_n   = bit_cnt + BW'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (last_cycle) begin
                    line_n  = FRAME_STOP;
                    state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                if (last_cycle) begin
                    line_n  = FRAME_STOP;
                    gap_n   = '0;
                    state_n = TX_GAP;
                end
            end
            TX_GAP: begin
                cyc_n  = '0;
                line_n = FRAME_STOP;
                if (gap_cnt == GW'(GAP_CYCLES - 1)) state_n = TX_IDLE;
                else                                gap_n   = gap_cnt + GW'(1);
            end
            default: begin
                line_n  = FRAME_STOP;
                state_n = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= TX_IDLE;
            cyc     <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shift   <= '0;
            parity  <= 1'b0;
            line    <= 1'b1;
        end else begin
            state   <= state_n;
            cyc     <= cyc_n;
            bit_cnt <= bit_n;
            gap_cnt <= gap_n;
            shift   <= shift_n;
            parity  <= par_n;
            line    <= line_n;
        end
    end

endmodule

// File: tb/tb_coin_serial_tx.sv
// Bench for coin_serial_tx: frame timeline model plus a slow-bit instance.
module tb_coin_serial_tx;

    localparam int AB = 1;
    localparam int AG = 1;
    localparam int AL = 5 * AB;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, coin_valid, coin_ready, serialOut, busy, tx_done;
    logic [1:0] coin_code;
    logic       rst_b, valid_b, ready_b, line_b, busy_b, done_b;
    logic [1:0] code_b;

    int total = 0;
    int bad   = 0;
    int now   = 0;

    // Model: every accepted coin becomes a frame scheduled at a start time.
    int         a_t[$];
    int         f_s[$];
    logic [1:0] f_c[$];
    int         next_free = 0;

    coin_serial_tx dut_a (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_code(coin_code),
        .coin_ready(coin_ready), .serialOut(serialOut), .busy(busy), .tx_done(tx_done)
    );

    coin_serial_tx #(.BIT_CYCLES(4), .GAP_CYCLES(3)) dut_b (
        .clk(clk), .reset(rst_b), .coin_valid(valid_b), .coin_code(code_b),
        .coin_ready(ready_b), .serialOut(line_b), .busy(busy_b), .tx_done(done_b)
    );

    function automatic logic fbit(input logic [1:0] c, input int k);
        case (k)
            0:       return 1'b0;
            1:       return c[0];
            2:       return c[1];
            3:       return c[0] ^ c[1];
            default: return 1'b1;
        endcase
    endfunction

    function automatic int m_count(input int e);
        int n = 0;
        foreach (a_t[i]) if (a_t[i] <= e) n++;
        foreach (f_s[i]) if (f_s[i] <= e) n--;
        return n;
    endfunction

    function automatic logic m_line(input int t);
        foreach (f_s[i])
            if (t >= f_s[i] && t < f_s[i] + AL) return fbit(f_c[i], (t - f_s[i]) / AB);
        return 1'b1;
    endfunction

    function automatic logic m_done(input int t);
        foreach (f_s[i]) if (t == f_s[i] + AL - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_busy(input int t);
        if (m_count(t) > 0) return 1'b1;
        foreach (f_s[i]) if (t >= f_s[i] && t <= f_s[i] + AL + AG - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_push(input int t, input logic [1:0] c);
        int s;
        s = (t + 1 > next_free) ? t + 1 : next_free;
        a_t.push_back(t);
        f_s.push_back(s);
        f_c.push_back(c);
        next_free = s + AL + AG + 1;
    endtask

    task automatic m_flush();
        a_t.delete();
        f_s.delete();
        f_c.delete();
        next_free = 0;
    endtask

    // One clock of DUT A: drive, sample ready before the edge, advance model.
    task automatic cycle(input logic v, input logic [1:0] c, input logic r,
                         output logic got_rdy, output logic exp_rdy);
        reset = r; coin_valid = v; coin_code = c;
        #1;
        got_rdy = coin_ready;
        exp_rdy = !r && (m_count(now) < DEPTH);
        @(posedge clk);
        now++;
        if (r) m_flush();
        else if (v && exp_rdy) m_push(now, c);
        #1;
    endtask

    task automatic test_reset();
        logic gr, er;
        logic [3:0] got;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), 1'b1, gr, er);
            got = {gr, serialOut, tx_done, busy};
            total++;
            if (got !== 4'b0100) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b want=0100", i, got);
            end
        end
        cycle(1'b0, 2'b00, 1'b0, gr, er);
        got = {gr, serialOut, tx_done, busy};
        total++;
        if (got !== 4'b1100) begin
            bad++;
            $display("FAIL reset_release got=%b want=1100", got);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 2'b00, 1'b0, gr, er);
            got = {gr, serialOut, tx_done, busy};
            total++;
            if (got !== {er, m_line(now), m_done(now), m_busy(now)}) begin
                bad++;
                $display("FAIL reset_idle t=%0d got=%b want=%b", now, got,
                         {er, m_line(now), m_done(now), m_busy(now)});
            end
        end
    endtask

    task automatic test_single_dime();
        logic gr, er;
        logic [3:0] got, want;
        logic [4:0] cap = '0;
        for (int i = 0; i < 10; i++) begin
            cycle(i == 0, 2'b01, 1'b0, gr, er);
            if (i >= 1 && i <= 5) cap = {cap[3:0], serialOut};
            got  = {gr, serialOut, tx_done, busy};
            want = {er, m_line(now), m_done(now), m_busy(now)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL dime t=%0d got=%b want=%b", now, got, want);
            end
        end
        total++;
        if (cap !== 5'b01011) begin
            bad++;
            $display("FAIL dime_bits got=%b want=01011", cap);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL dime_busy_end got=%b want=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic gr, er;
        logic [3:0] got, want;
        logic [11:0] cap = '0;
        for (int i = 0; i < 16; i++) begin
            cycle(i < 2, (i == 0) ? 2'b10 : 2'b11, 1'b0, gr, er);
            if (i >= 1 && i <= 12) cap = {cap[10:0], serialOut};
            got  = {gr, serialOut, tx_done, busy};
            want = {er, m_line(now), m_done(now), m_busy(now)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL b2b t=%0d got=%b want=%b", now, got, want);
            end
        end
        total++;
        if (cap !== 12'b001111101101) begin
            bad++;
            $display("FAIL b2b_bits got=%b want=001111101101", cap);
        end
    endtask

    task automatic test_fill_queue();
        logic gr, er, v;
        logic [3:0] got, want;
        logic [1:0] seq [6];
        int pushed = 0, dones = 0, stalls = 0;
        seq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        for (int i = 0; i < 80; i++) begin
            v = (pushed < 6);
            cycle(v, seq[v ? pushed : 0], 1'b0, gr, er);
            if (v && er) pushed++;
            if (v && !gr) stalls++;
            if (tx_done === 1'b1) dones++;
            got  = {gr, serialOut, tx_done, busy};
            want = {er, m_line(now), m_done(now), m_busy(now)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL fill t=%0d got=%b want=%b", now, got, want);
            end
        end
        total++;
        if (dones !== 6) begin
            bad++;
            $display("FAIL fill_done_count got=%0d want=6", dones);
        end
        total++;
        if ((stalls != 0) !== 1'b1) begin
            bad++;
            $display("FAIL fill_ready_drop got=%0d stalled cycles want>0", stalls);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic gr, er;
        logic [3:0] got, want;
        cycle(1'b1, 2'b00, 1'b0, gr, er);
        cycle(1'b1, 2'b01, 1'b0, gr, er);
        cycle(1'b1, 2'b10, 1'b0, gr, er);
        cycle(1'b0, 2'b00, 1'b0, gr, er);
        cycle(1'b0, 2'b00, 1'b1, gr, er);
        got = {gr, serialOut, tx_done, busy};
        total++;
        if (got !== 4'b0100) begin
            bad++;
            $display("FAIL midreset_edge got=%b want=0100", got);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 2'b00, 1'b0, gr, er);
            got  = {gr, serialOut, tx_done, busy};
            want = {er, m_line(now), m_done(now), m_busy(now)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL midreset_after t=%0d got=%b want=%b", now, got, want);
            end
        end
    endtask

    task automatic test_random();
        logic gr, er, r, v;
        logic [3:0] got, want;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 2) != 0);
            cycle(v, 2'($urandom_range(0, 3)), r, gr, er);
            got  = {gr, serialOut, tx_done, busy};
            want = {er, m_line(now), m_done(now), m_busy(now)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL random t=%0d got=%b want=%b", now, got, want);
            end
        end
    endtask

    task automatic test_slow_bits();
        int n0 = 0, s1, s2, t;
        logic [2:0] got, want;
        logic el;
        rst_b = 1'b1; valid_b = 1'b0; code_b = 2'b01;
        @(posedge clk); now++; #1;
        rst_b = 1'b0;
        for (int i = 0; i < 62; i++) begin
            valid_b = (i < 2);
            @(posedge clk);
            now++;
            if (i == 0) n0 = now;
            #1;
            t  = now;
            s1 = n0 + 1;
            s2 = s1 + 20 + 3 + 1;
            if (t >= s1 && t < s1 + 20)      el = fbit(2'b01, (t - s1) / 4);
            else if (t >= s2 && t < s2 + 20) el = fbit(2'b01, (t - s2) / 4);
            else                             el = 1'b1;
            want = {el, (t == s1 + 19) || (t == s2 + 19), (t >= n0) && (t <= s2 + 22)};
            got  = {line_b, done_b, busy_b};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL slow t=%0d got=%b want=%b", t - n0, got, want);
            end
        end
        valid_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1; coin_valid = 1'b0; coin_code = 2'b00;
        rst_b = 1'b1; valid_b = 1'b0; code_b = 2'b00;
        @(posedge clk); #1;
        test_reset();
        test_single_dime();
        test_back_to_back();
        test_fill_queue();
        test_reset_mid_frame();
        test_random();
        test_slow_bits();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
